// File: rtl/lpf_frame_sequencer.sv
// Frame sequencer for the frequency-domain LPF: per-beat bin index, frame counting, length-error resync.
// Optional macro LPF_SEQ_ERR_CNT_EN adds err_cnt / err_clr.
`timescale 1ns/1ps
module lpf_frame_sequencer #(
  parameter int unsigned FFT_LEN       = 8192,
  parameter int unsigned INDEX_LEN     = 32,
  parameter int unsigned FRAME_CNT_LEN = 32,
  parameter int unsigned INIT_CUTOFF   = FFT_LEN / 2
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  input  logic [INDEX_LEN-1:0]     cfg_cutoff,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic [INDEX_LEN-1:0]     index,
  output logic [INDEX_LEN-1:0]     cutoff,
  output logic [FRAME_CNT_LEN-1:0] frame_cnt,
  output logic                     in_frame,
  output logic                     len_err,
  output logic                     err_short,
  output logic                     err_long,
  output logic [1:0]               dbg_state
`ifdef LPF_SEQ_ERR_CNT_EN
  ,
  input  logic                     err_clr,
  output logic [15:0]              err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FRAME  = 2'd1,
    S_RESYNC = 2'd2
  } state_t;

  localparam logic [INDEX_LEN-1:0] LAST   = INDEX_LEN'(FFT_LEN - 1);
  localparam logic                 SINGLE = (FFT_LEN == 1);

  state_t                   r_state;
  logic [INDEX_LEN-1:0]     r_index;
  logic [INDEX_LEN-1:0]     r_cutoff;
  logic [INDEX_LEN-1:0]     r_shadow;
  logic                     r_pending;
  logic                     r_cfg_ready;
  logic [FRAME_CNT_LEN-1:0] r_frame_cnt;
  logic                     r_in_frame;
  logic                     r_len_err;
  logic                     r_err_short;
  logic                     r_err_long;

  logic                 w_at_last;
  logic                 w_beat_end;
  logic                 w_good;
  logic                 w_short;
  logic                 w_long;
  logic                 w_err;
  logic                 w_close;
  logic                 w_apply;
  logic                 w_xfer;
  logic [INDEX_LEN-1:0] w_clamped;

  assign w_at_last  = (r_index == LAST);
  assign w_beat_end = s_tvalid && s_tlast;
  assign w_good     = w_beat_end && ((r_state == S_FRAME && w_at_last) || (r_state == S_IDLE && SINGLE));
  assign w_short    = w_beat_end && ((r_state == S_FRAME && !w_at_last) || (r_state == S_IDLE && !SINGLE));
  assign w_long     = s_tvalid && !s_tlast &&
                      ((r_state == S_FRAME && w_at_last) || (r_state == S_IDLE && SINGLE));
  assign w_err      = w_short || w_long;
  // A frame closes on any tlast seen while a frame is open; an early tlast in IDLE opens nothing.
  assign w_close    = w_beat_end && (r_state == S_FRAME || r_state == S_RESYNC || (r_state == S_IDLE && SINGLE));

  // cfg handshake: a request transfers on an edge where cfg_valid && cfg_ready; cfg_ready then
  // stays low until the shadow value is applied, so at most one request is ever outstanding.
  assign w_xfer     = cfg_valid && r_cfg_ready;
  assign w_apply    = r_pending && (w_close || (r_state == S_IDLE && !s_tvalid));
  assign w_clamped  = (cfg_cutoff > LAST) ? LAST : cfg_cutoff;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_cutoff    <= INDEX_LEN'(INIT_CUTOFF);
      r_shadow    <= '0;
      r_pending   <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_frame_cnt <= '0;
      r_in_frame  <= 1'b0;
      r_len_err   <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_len_err <= w_err;
      if (w_good) r_frame_cnt <= r_frame_cnt + FRAME_CNT_LEN'(1);
`ifdef LPF_SEQ_ERR_CNT_EN
      if (err_clr) begin
        r_err_short <= 1'b0;
        r_err_long  <= 1'b0;
      end else begin
        if (w_short) r_err_short <= 1'b1;
        if (w_long)  r_err_long  <= 1'b1;
      end
`else
      if (w_short) r_err_short <= 1'b1;
      if (w_long)  r_err_long  <= 1'b1;
`endif
      if (w_xfer) begin
        r_shadow    <= w_clamped;
        r_pending   <= 1'b1;
        r_cfg_ready <= 1'b0;
      end else if (w_apply) begin
        r_cutoff    <= r_shadow;
        r_pending   <= 1'b0;
        r_cfg_ready <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (s_tvalid && !s_tlast) begin
            r_in_frame <= 1'b1;
            if (SINGLE) begin
              r_state <= S_RESYNC;
            end else begin
              r_state <= S_FRAME;
              r_index <= INDEX_LEN'(1);
            end
          end
        end
        S_FRAME: begin
          if (s_tvalid) begin
            if (s_tlast) begin
              r_state    <= S_IDLE;
              r_index    <= '0;
              r_in_frame <= 1'b0;
            end else if (w_at_last) begin
              r_state <= S_RESYNC;
            end else begin
              r_index <= r_index + INDEX_LEN'(1);
            end
          end
        end
        S_RESYNC: begin
          if (w_beat_end) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_in_frame <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_index    <= '0;
          r_in_frame <= 1'b0;
        end
      endcase
    end
  end

`ifdef LPF_SEQ_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= w_err ? 16'd1 : 16'd0;
    end else if (w_err && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign cfg_ready = r_cfg_ready;
  assign index     = r_index;
  assign cutoff    = r_cutoff;
  assign frame_cnt = r_frame_cnt;
  assign in_frame  = r_in_frame;
  assign len_err   = r_len_err;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;
  assign dbg_state = r_state;

endmodule
